// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
//
// Round-robin arbiter for a multi-master AHB bus. It decides which master may
// drive the next address phase. Fixed-length bursts (4/8/16 beats) and locked
// sequences are never split. INCR and SINGLE transfers can be preempted on any
// completed beat.
//
// Ports
//   hclk_i          bus clock; all state changes on the rising edge
//   hreset_i        synchronous active-high reset
//   hbusreq_i       per-master bus request
//   hlock_i         per-master locked-access request
//   htrans_i        HTRANS of the current address-phase owner
//   hburst_i        HBURST of the current address-phase owner
//   hready_i        HREADY; state only advances when it is 1
//   hresp_i         HRESP (1 = ERROR); aborts any burst in progress
//   hgrant_o        one-hot grant, registered
//   hmaster_o       index of the address-phase owner, registered
//   hmasterlock_o   the owner's current transfer is locked, registered
// -----------------------------------------------------------------------------
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int HMASTER_WIDTH  = 8,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                     hclk_i,
   input  logic                     hreset_i,
   input  logic [NUM_MASTERS-1:0]   hbusreq_i,
   input  logic [NUM_MASTERS-1:0]   hlock_i,
   input  logic [1:0]               htrans_i,
   input  logic [2:0]               hburst_i,
   input  logic                     hready_i,
   input  logic                     hresp_i,
   output logic [NUM_MASTERS-1:0]   hgrant_o,
   output logic [HMASTER_WIDTH-1:0] hmaster_o,
   output logic                     hmasterlock_o
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_PARK,
      ST_OWN,
      ST_BURST,
      ST_LOCK
   } state_e;

   state_e                    state_q, state_d;
   logic [NUM_MASTERS-1:0]    hgrant_q, hgrant_d;
   logic [HMASTER_WIDTH-1:0]  hmaster_q, hmaster_d;
   logic                      hmasterlock_q, hmasterlock_d;
   logic [4:0]                beat_cnt_q, beat_cnt_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;

   logic [IDX_W-1:0]          gidx;       // index of the currently granted master
   logic [IDX_W-1:0]          cand [NUM_MASTERS];
   logic [IDX_W-1:0]          winner;
   logic                      req_found;
   logic                      lock_hold;
   logic                      burst_hold;

   // Search order for round-robin: cand[0] is the master just after rr_ptr,
   // cand[NUM_MASTERS-1] is rr_ptr itself (lowest priority).
   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
         assign cand[gi] = IDX_W'((int'(rr_ptr_q) + gi + 1) % NUM_MASTERS);
      end
   endgenerate

   // One-hot to index of the current grant.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (hgrant_q[i]) begin
            gidx = gidx | IDX_W'(i);
         end
      end
   end

   // First requester in round-robin order.
   always_comb begin
      req_found = 1'b0;
      winner    = rr_ptr_q;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!req_found && hbusreq_i[cand[i]]) begin
            req_found = 1'b1;
            winner    = cand[i];
         end
      end
   end

   // Remaining-beat counter. It holds len-1 after the first beat of a fixed
   // burst, so the grant may move on the beat that leaves one beat to go and
   // the next owner's address phase lines up with the final data beat.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (hresp_i || (htrans_i == HTRANS_IDLE)) begin
         beat_cnt_d = 5'd0;
      end else if (htrans_i == HTRANS_NONSEQ) begin
         unique case (hburst_i)
            3'b010, 3'b011: beat_cnt_d = 5'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: beat_cnt_d = 5'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: beat_cnt_d = 5'd15;  // WRAP16 / INCR16
            default:        beat_cnt_d = 5'd0;   // SINGLE / INCR
         endcase
      end else if (htrans_i == HTRANS_SEQ) begin
         if (beat_cnt_q != 5'd0) begin
            beat_cnt_d = beat_cnt_q - 5'd1;
         end
      end else if (htrans_i == HTRANS_BUSY) begin
         beat_cnt_d = beat_cnt_q;
      end
   end

   // hmasterlock_q keeps the grant for one transfer after hlock drops, so the
   // last locked transfer completes before anyone else gets the bus.
   assign lock_hold  = hmasterlock_q | hlock_i[gidx];
   assign burst_hold = (beat_cnt_d > 5'd1);

   always_comb begin
      state_d       = state_q;
      hgrant_d      = hgrant_q;
      hmaster_d     = hmaster_q;
      hmasterlock_d = hmasterlock_q;
      rr_ptr_d      = rr_ptr_q;
      if (hready_i) begin
         hmaster_d     = HMASTER_WIDTH'(gidx);
         hmasterlock_d = hlock_i[gidx];
         if (lock_hold) begin
            state_d = ST_LOCK;
         end else if (burst_hold) begin
            state_d = ST_BURST;
         end else if (req_found) begin
            hgrant_d = NUM_MASTERS'(1) << winner;
            rr_ptr_d = winner;
            state_d  = ST_OWN;
         end else begin
            hgrant_d = DEF_GRANT;
            state_d  = ST_PARK;
         end
      end
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         state_q       <= ST_PARK;
         hgrant_q      <= DEF_GRANT;
         hmaster_q     <= HMASTER_WIDTH'(DEF_IDX);
         hmasterlock_q <= 1'b0;
         beat_cnt_q    <= 5'd0;
         rr_ptr_q      <= DEF_IDX;
      end else if (hready_i) begin
         state_q       <= state_d;
         hgrant_q      <= hgrant_d;
         hmaster_q     <= hmaster_d;
         hmasterlock_q <= hmasterlock_d;
         beat_cnt_q    <= beat_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign hgrant_o      = hgrant_q;
   assign hmaster_o     = hmaster_q;
   assign hmasterlock_o = hmasterlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Directed scenarios with literal expectations, then a long randomized run.
// A behavioural model (integer beat count, distance-based round-robin pick)
// predicts hgrant/hmaster/hmasterlock after every clock edge.
// -----------------------------------------------------------------------------
module tb_ahb_arbiter;

   localparam int N = 4;

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;
   logic       hresp;
   logic [3:0] hgrant;
   logic [7:0] hmaster;
   logic       hmasterlock;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   ahb_arbiter #(
      .NUM_MASTERS   (4),
      .HMASTER_WIDTH (8),
      .DEFAULT_MASTER(0)
   ) dut (
      .hclk_i       (hclk),
      .hreset_i     (hreset),
      .hbusreq_i    (hbusreq),
      .hlock_i      (hlock),
      .htrans_i     (htrans),
      .hburst_i     (hburst),
      .hready_i     (hready),
      .hresp_i      (hresp),
      .hgrant_o     (hgrant),
      .hmaster_o    (hmaster),
      .hmasterlock_o(hmasterlock)
   );

   // ---------------- behavioural model ----------------
   logic [1:0] m_grant;
   logic [1:0] m_owner;
   logic [1:0] m_rr;
   logic       m_lock;
   int         m_cnt;
   bit         m_valid = 1'b0;
   int         len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int         nc;
      bit         held;
      int         best;
      int         bestd;
      int         d;
      logic [1:0] cc;
      logic [1:0] old_g;
      if (hreset) begin
         m_grant = 2'd0;
         m_owner = 2'd0;
         m_lock  = 1'b0;
         m_cnt   = 0;
         m_rr    = 2'd0;
         m_valid = 1'b1;
      end else if (m_valid && hready) begin
         if (hresp || htrans == 2'b00)      nc = 0;
         else if (htrans == 2'b10)          nc = len_tab[hburst] - 1;
         else if (htrans == 2'b11)          nc = (m_cnt > 0) ? m_cnt - 1 : 0;
         else                               nc = m_cnt;
         old_g = m_grant;
         held  = m_lock || hlock[old_g] || (nc > 1);
         if (!held) begin
            best  = -1;
            bestd = N;
            for (int c = 0; c < N; c++) begin
               cc = 2'(c);
               if (hbusreq[cc]) begin
                  d = (c - int'(m_rr) - 1 + 2 * N) % N;
                  if (d < bestd) begin
                     bestd = d;
                     best  = c;
                  end
               end
            end
            if (best >= 0) begin
               m_grant = 2'(best);
               m_rr    = 2'(best);
            end else begin
               m_grant = 2'd0;
            end
         end
         m_owner = old_g;
         m_lock  = hlock[old_g];
         m_cnt   = nc;
      end
   endtask

   // Compare process: model advances on each edge, DUT checked 1 time unit later.
   initial begin
      logic [3:0] eg;
      forever begin
         @(posedge hclk);
         model_step();
         #1;
         if (m_valid) begin
            eg = 4'b0001 << m_grant;
            chk("model_hgrant", {28'd0, hgrant}, {28'd0, eg});
            chk("model_hmaster", {24'd0, hmaster}, {30'd0, m_owner});
            chk("model_hmasterlock", {31'd0, hmasterlock}, {31'd0, m_lock});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge hclk);
   endtask

   task automatic idle_in();
      hbusreq = 4'b0000;
      hlock   = 4'b0000;
      htrans  = 2'b00;
      hburst  = 3'b000;
      hready  = 1'b1;
      hresp   = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      hreset = 1'b1;
      step();
      hreset = 1'b0;
   endtask

   initial begin
      logic [3:0] rot [5];
      logic [3:0] lockreg;
      int         r;
      rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      // Reset and parking
      do_reset();
      chk("rst_hgrant", {28'd0, hgrant}, 32'h1);
      chk("rst_hmaster", {24'd0, hmaster}, 32'h0);
      chk("rst_hmasterlock", {31'd0, hmasterlock}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("park_hgrant", {28'd0, hgrant}, 32'h1);
         chk("park_hmaster", {24'd0, hmaster}, 32'h0);
      end

      // Round-robin rotation with all masters requesting SINGLE transfers
      hbusreq = 4'b1111;
      htrans  = 2'b10;
      hburst  = 3'b000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_hgrant", {28'd0, hgrant}, {28'd0, rot[i]});
      end

      // M2 INCR8 with M1 requesting from beat 2, stall mid-burst
      do_reset();
      hbusreq = 4'b0100;
      step();
      chk("b8_grant_m2", {28'd0, hgrant}, 32'h4);
      step();
      chk("b8_owner_m2", {24'd0, hmaster}, 32'h2);
      htrans = 2'b10;
      hburst = 3'b101;
      step();
      chk("b8_beat1", {28'd0, hgrant}, 32'h4);
      hbusreq = 4'b0110;
      htrans  = 2'b11;
      for (int beat = 2; beat <= 8; beat++) begin
         if (beat == 4) begin
            hready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               chk("b8_stall_hgrant", {28'd0, hgrant}, 32'h4);
               chk("b8_stall_hmaster", {24'd0, hmaster}, 32'h2);
            end
            hready = 1'b1;
         end
         if (beat == 8) hbusreq = 4'b0010;
         step();
         if (beat <= 6) chk("b8_hold", {28'd0, hgrant}, 32'h4);
      end
      chk("b8_handover_hgrant", {28'd0, hgrant}, 32'h2);
      chk("b8_handover_hmaster", {24'd0, hmaster}, 32'h1);

      // M3 locked for 5 transfers with M0 requesting
      do_reset();
      hbusreq = 4'b1001;
      step();
      chk("lk_grant_m3", {28'd0, hgrant}, 32'h8);
      hlock  = 4'b1000;
      htrans = 2'b10;
      hburst = 3'b000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("lk_hold_hgrant", {28'd0, hgrant}, 32'h8);
         chk("lk_hmasterlock", {31'd0, hmasterlock}, 32'h1);
      end
      hlock = 4'b0000;
      step();
      chk("lk_extra_hgrant", {28'd0, hgrant}, 32'h8);
      chk("lk_extra_hmasterlock", {31'd0, hmasterlock}, 32'h0);
      step();
      chk("lk_release_hgrant", {28'd0, hgrant}, 32'h1);
      chk("lk_release_hmaster", {24'd0, hmaster}, 32'h3);

      // M1 WRAP4 aborted by ERROR on beat 2, M2 waiting
      do_reset();
      hbusreq = 4'b0010;
      step();
      chk("err_grant_m1", {28'd0, hgrant}, 32'h2);
      step();
      htrans  = 2'b10;
      hburst  = 3'b010;
      hbusreq = 4'b0110;
      step();
      chk("err_beat1", {28'd0, hgrant}, 32'h2);
      htrans = 2'b11;
      hready = 1'b0;
      hresp  = 1'b1;
      step();
      chk("err_wait_hgrant", {28'd0, hgrant}, 32'h2);
      hready = 1'b1;
      step();
      chk("err_move_hgrant", {28'd0, hgrant}, 32'h4);
      hresp  = 1'b0;
      htrans = 2'b00;

      // Reset in the middle of an M2 INCR16
      do_reset();
      hbusreq = 4'b0100;
      step();
      step();
      htrans = 2'b10;
      hburst = 3'b111;
      step();
      htrans = 2'b11;
      step();
      step();
      chk("rs16_mid_hgrant", {28'd0, hgrant}, 32'h4);
      hreset = 1'b1;
      step();
      chk("rs16_hgrant", {28'd0, hgrant}, 32'h1);
      chk("rs16_hmaster", {24'd0, hmaster}, 32'h0);
      chk("rs16_hmasterlock", {31'd0, hmasterlock}, 32'h0);
      hreset  = 1'b0;
      hbusreq = 4'b0010;
      step();
      chk("rs16_cnt_cleared", {28'd0, hgrant}, 32'h2);

      // Randomized run
      lockreg = 4'b0000;
      for (int n = 0; n < 4000; n++) begin
         hreset  = ($urandom_range(0, 199) == 0);
         hbusreq = 4'($urandom);
         for (int m = 0; m < N; m++) begin
            if ($urandom_range(0, 9) == 0) lockreg[m] = ~lockreg[m];
         end
         hlock = lockreg;
         r = $urandom_range(0, 9);
         if (r < 2)       htrans = 2'b00;
         else if (r == 2) htrans = 2'b01;
         else if (r < 5)  htrans = 2'b10;
         else             htrans = 2'b11;
         hburst = 3'($urandom);
         hready = ($urandom_range(0, 4) != 0);
         hresp  = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
